// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite block-ROM read port among NUM_REQ layers: latch all requests per pixel,
// issue them in slot order, capture the returning colours and publish them together with done.

module sprite_rom_arbiter_lane #(
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] TRANSPARENT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic              cap_vld,
  input  logic              commit,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit
);
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] work_q, work_d, rsp_q, rsp_d;
  logic              hitw_q, hitw_d, hit_q, hit_d;

  // The commit reads work_d, so the slot captured on the commit edge is written through.
  always_comb begin
    word   = cap_vld ? rom_data : TRANSPARENT;
    work_d = work_q;
    hitw_d = hitw_q;
    rsp_d  = rsp_q;
    hit_d  = hit_q;
    if (cap_en) begin
      work_d = word;
      hitw_d = cap_vld;
    end
    if (commit) begin
      rsp_d = work_d;
      hit_d = hitw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= TRANSPARENT;
      hitw_q <= 1'b0;
      rsp_q  <= TRANSPARENT;
      hit_q  <= 1'b0;
    end else begin
      work_q <= work_d;
      hitw_q <= hitw_d;
      rsp_q  <= rsp_d;
      hit_q  <= hit_d;
    end
  end

  assign rsp_data = rsp_q;
  assign rsp_hit  = hit_q;
endmodule

module sprite_rom_arbiter #(
  parameter int                NUM_REQ     = 4,
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 16,
  parameter int                ROM_LAT     = 1,
  parameter logic [DATA_W-1:0] TRANSPARENT = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_tick,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  output logic [NUM_REQ-1:0]        rsp_hit,
  output logic                      done,
  output logic                      overrun
);
  localparam int                IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic { IDLE, ISSUE } state_t;

  typedef struct packed {
    logic             act;
    logic [IDX_W-1:0] idx;
    logic             vld;
    logic             last;
  } iss_t;

  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] rsp_data_a;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               slot_q, slot_d;
  logic [NUM_REQ-1:0]             sh_vld_q, sh_vld_d;
  logic [NUM_REQ-1:0][ADDR_W-1:0] sh_addr_q, sh_addr_d;
  logic                           overrun_q, overrun_d;
  logic                           done_q, done_d;
  iss_t [ROM_LAT-1:0]             dl_q, dl_d;
  iss_t                           iss, cap;
  logic                           commit;

  assign req_addr_a = req_addr;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    sh_vld_d  = sh_vld_q;
    sh_addr_d = sh_addr_q;
    overrun_d = overrun_q;
    rom_en    = 1'b0;
    rom_addr  = '0;
    iss       = '0;
    unique case (state_q)
      IDLE: begin
        if (pix_tick) begin
          sh_vld_d  = req_valid;
          sh_addr_d = req_addr_a;
          slot_d    = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        rom_en   = sh_vld_q[slot_q];
        rom_addr = sh_vld_q[slot_q] ? sh_addr_q[slot_q] : '0;
        iss.act  = 1'b1;
        iss.idx  = slot_q;
        iss.vld  = sh_vld_q[slot_q];
        iss.last = (slot_q == LAST);
        if (slot_q != LAST) begin
          slot_d = slot_q + 1'b1;
          // Mid-sequence ticks are dropped; the shadow set stays intact.
          if (pix_tick) overrun_d = 1'b1;
        end else if (pix_tick) begin
          sh_vld_d  = req_valid;
          sh_addr_d = req_addr_a;
          slot_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue tags ride alongside the ROM so each returning word knows its slot.
  always_comb begin
    dl_d    = dl_q;
    dl_d[0] = iss;
    for (int j = 1; j < ROM_LAT; j++) dl_d[j] = dl_q[j-1];
    cap    = dl_q[ROM_LAT-1];
    commit = cap.act & cap.last;
    done_d = commit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      sh_vld_q  <= '0;
      sh_addr_q <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      dl_q      <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      sh_vld_q  <= sh_vld_d;
      sh_addr_q <= sh_addr_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      dl_q      <= dl_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    sprite_rom_arbiter_lane #(
      .DATA_W      (DATA_W),
      .TRANSPARENT (TRANSPARENT)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .cap_en   (cap.act && (cap.idx == IDX_W'(g))),
      .cap_vld  (cap.vld),
      .commit   (commit),
      .rom_data (rom_data),
      .rsp_data (rsp_data_a[g]),
      .rsp_hit  (rsp_hit[g])
    );
  end

  assign rsp_data = rsp_data_a;
  assign done     = done_q;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed plus randomized bench for sprite_rom_arbiter; expectations come from a
// cycle-schedule model of accepted ticks (issue cycles, commit cycle, sticky overrun).

module tb_sprite_rom_arbiter;
  localparam int NR  = 4;
  localparam int AW  = 19;
  localparam int DW  = 16;
  localparam int LAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pix_tick = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic             rom_en;
  logic [AW-1:0]    rom_addr;
  logic [DW-1:0]    rom_data = '0;
  logic [NR*DW-1:0] rsp_data;
  logic [NR-1:0]    rsp_hit;
  logic             done, overrun;

  int vectors = 0, miscompares = 0, cyc = 0;

  // Model state: expected ROM issues and commits keyed by absolute cycle number.
  logic [AW:0]      exp_iss   [int];
  logic [NR*DW-1:0] exp_cdata [int];
  logic [NR-1:0]    exp_chit  [int];
  logic [NR*DW-1:0] m_rsp;
  logic [NR-1:0]    m_hit;
  logic             m_ovr;
  int               m_last;

  sprite_rom_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .TRANSPARENT(16'hFFFF)
  ) dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .req_valid(req_valid), .req_addr(req_addr),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // One-cycle-latency block ROM whose contents are addr[15:0]^A5A5.
  always @(posedge clk) if (rom_en) rom_data <= rom_addr[15:0] ^ 16'hA5A5;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_iss.delete();
    exp_cdata.delete();
    exp_chit.delete();
    m_rsp  = {NR{16'hFFFF}};
    m_hit  = '0;
    m_ovr  = 1'b0;
    m_last = -1000;
  endtask

  function automatic logic [NR*AW-1:0] addrs(int a0, int a1, int a2, int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [NR*AW-1:0] rand_addrs();
    logic [NR*AW-1:0] a;
    for (int i = 0; i < NR; i++) a[i*AW +: AW] = AW'($urandom);
    return a;
  endfunction

  // Drive one cycle's inputs, check that cycle's outputs, then advance the model past the edge.
  task automatic step(bit r, bit t, logic [NR-1:0] v, logic [NR*AW-1:0] a, bit do_chk = 1'b1);
    logic [AW:0]      e_iss;
    logic [NR*DW-1:0] d;
    rst = r; pix_tick = t; req_valid = v; req_addr = a;
    @(negedge clk);
    if (exp_cdata.exists(cyc)) begin
      m_rsp = exp_cdata[cyc];
      m_hit = exp_chit[cyc];
    end
    if (do_chk) begin
      e_iss = exp_iss.exists(cyc) ? exp_iss[cyc] : '0;
      chk("rom_en",   64'(rom_en),   64'(e_iss[AW]));
      chk("rom_addr", 64'(rom_addr), 64'(e_iss[AW-1:0]));
      chk("done",     64'(done),     64'(exp_cdata.exists(cyc)));
      chk("rsp_data", 64'(rsp_data), 64'(m_rsp));
      chk("rsp_hit",  64'(rsp_hit),  64'(m_hit));
      chk("overrun",  64'(overrun),  64'(m_ovr));
    end
    if (r) model_reset();
    else if (t) begin
      if (cyc >= m_last + NR) begin
        m_last = cyc;
        for (int i = 0; i < NR; i++) begin
          exp_iss[cyc+1+i] = {v[i], v[i] ? a[i*AW +: AW] : AW'(0)};
          d[i*DW +: DW] = v[i] ? (a[i*AW +: DW] ^ 16'hA5A5) : 16'hFFFF;
        end
        exp_cdata[cyc+NR+LAT+1] = d;
        exp_chit[cyc+NR+LAT+1]  = v;
      end else begin
        m_ovr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [15:0] w;
    model_reset();
    @(posedge clk);
    #1;
    // T1: reset held two cycles
    step(1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0);

    // T2: single pixel, known addresses
    step(1'b0, 1'b1, 4'hF, addrs(0, 10, 20, 30));
    idle(7);
    chk("t2_rsp_const", 64'(rsp_data), 64'hA5BB_A5B1_A5AF_A5A5);
    chk("t2_hit_const", 64'(rsp_hit), 64'hF);

    // T3: slot 1 outside its window
    step(1'b0, 1'b1, 4'b1101, rand_addrs());
    idle(7);
    w = rsp_data[31:16];
    chk("t3_slot1_transp", 64'(w), 64'hFFFF);
    chk("t3_hit_const", 64'(rsp_hit), 64'hD);

    // T4: back-to-back stream at minimum spacing
    for (int p = 0; p < 3; p++) begin
      step(1'b0, 1'b1, 4'(p + 13), rand_addrs());
      idle(NR - 1);
    end
    idle(4);
    chk("t4_no_overrun", 64'(overrun), 64'h0);

    // T5: second tick two cycles later is dropped
    step(1'b0, 1'b1, 4'hF, rand_addrs());
    idle(1);
    step(1'b0, 1'b1, 4'hF, rand_addrs());
    idle(6);
    chk("t5_overrun_sticky", 64'(overrun), 64'h1);

    // T6: reset during the slot-2 cycle, with a tick in the same cycle
    step(1'b0, 1'b1, 4'hF, rand_addrs());
    idle(2);
    step(1'b1, 1'b1, 4'hF, rand_addrs());
    idle(6);
    chk("t6_rsp_reset", 64'(rsp_data), {4{16'hFFFF}});
    step(1'b0, 1'b1, 4'hB, rand_addrs());
    idle(7);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++)
      step(1'b0 || ($urandom_range(0, 59) == 0), $urandom_range(0, 2) == 0,
           NR'($urandom), rand_addrs());
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
